// File: rtl/aes_word_seq_if.sv
// Word streams between the AXI-side logic and the AES word sequencer.
// The sequencer takes the slave view; the stream source/sink takes the master view.
`timescale 1ns/1ps
interface aes_word_seq_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_is_key;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  modport slave (
    input  s_valid, s_data, s_is_key, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, s_is_key, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/aes_word_seq.sv
// Word-serial front end for the 128-bit AES core: assembles 4-word key/plaintext
// packets, pulses Krdy/Drdy, waits out BSY and streams the ciphertext back out.
`timescale 1ns/1ps
module aes_word_seq #(
  parameter int CNT_W = 16
) (
  input  logic               CLK,
  input  logic               RSTn,
  aes_word_seq_if.slave      strm,
  output logic [127:0]       core_kin,
  output logic [127:0]       core_din,
  output logic               core_krdy,
  output logic               core_drdy,
  output logic               core_en,
  input  logic               core_bsy,
  input  logic [127:0]       core_dout,
  output logic               key_loaded,
  output logic [CNT_W-1:0]   blk_cnt
);
  localparam int         WORDS    = 4;
  localparam logic [1:0] LAST_IDX = 2'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KPULSE, S_DPULSE, S_SETTLE, S_WAIT, S_OUT
  } state_t;

  state_t       state, state_nxt;
  logic [1:0]   idx;
  logic         pkt_key;
  logic         live;
  logic [127:0] asm_q;
  logic [127:0] out_q;
  logic         s_hs;
  logic         m_hs;

  // live keeps s_ready and core_en low for as long as reset is held.
  assign strm.s_ready = live && (state == S_IDLE || state == S_LOAD);
  assign strm.m_valid = (state == S_OUT);
  assign s_hs         = strm.s_valid && strm.s_ready;
  assign m_hs         = strm.m_valid && strm.m_ready;

  assign core_kin = asm_q;
  assign core_din = asm_q;
  assign core_en  = live;

  always_ff @(posedge CLK or negedge RSTn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!RSTn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt   = state;
    strm.m_data = '0;
    strm.m_last = 1'b0;
    core_krdy   = 1'b0;
    core_drdy   = 1'b0;
    unique case (state)
      S_IDLE:   if (s_hs) state_nxt = S_LOAD;
      S_LOAD:   if (s_hs && idx == LAST_IDX) state_nxt = pkt_key ? S_KPULSE : S_DPULSE;
      S_KPULSE: begin
        core_krdy = 1'b1;
        state_nxt = S_SETTLE;
      end
      S_DPULSE: begin
        core_drdy = 1'b1;
        state_nxt = S_SETTLE;
      end
      // BSY is registered inside the core, so it is not meaningful until the cycle after this one.
      S_SETTLE: state_nxt = S_WAIT;
      S_WAIT:   if (!core_bsy) state_nxt = pkt_key ? S_IDLE : S_OUT;
      S_OUT: begin
        strm.m_data = out_q[{idx, 5'd0} +: 32];
        strm.m_last = (idx == LAST_IDX);
        if (m_hs && idx == LAST_IDX) state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      // NOTE: the wide assembly/output registers are reset because core_kin/core_din must read zero in reset.
      live       <= 1'b0;
      idx        <= 2'd0;
      pkt_key    <= 1'b0;
      asm_q      <= '0;
      out_q      <= '0;
      key_loaded <= 1'b0;
      blk_cnt    <= '0;
    end else begin
      live <= 1'b1;
      // idx wraps 3 -> 0 at the end of both LOAD and OUT, so IDLE always starts at word 0.
      if (s_hs) begin
        asm_q[{idx, 5'd0} +: 32] <= strm.s_data;
        idx                      <= idx + 2'd1;
        if (state == S_IDLE) pkt_key <= strm.s_is_key;
      end
      if (m_hs) idx <= idx + 2'd1;
      if (state == S_KPULSE) key_loaded <= 1'b1;
      if (state == S_WAIT && !core_bsy && !pkt_key) begin
        out_q   <= core_dout;
        blk_cnt <= blk_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_aes_word_seq.sv
// Self-checking bench for aes_word_seq: behavioural AES core stand-in with a
// programmable BSY length, directed FIPS-197 steps and randomized plaintext blocks.
`timescale 1ns/1ps
module tb_aes_word_seq;
  localparam int CNT_W = 2;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic               CLK  = 1'b0;
  logic               RSTn = 1'b1;
  logic [127:0]       core_kin, core_din, core_dout;
  logic               core_krdy, core_drdy, core_en, core_bsy, key_loaded;
  logic [CNT_W-1:0]   blk_cnt;

  aes_word_seq_if strm();

  aes_word_seq #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RSTn(RSTn), .strm(strm),
    .core_kin(core_kin), .core_din(core_din),
    .core_krdy(core_krdy), .core_drdy(core_drdy), .core_en(core_en),
    .core_bsy(core_bsy), .core_dout(core_dout),
    .key_loaded(key_loaded), .blk_cnt(blk_cnt)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model state: the key the core should hold, expected flags/counter.
  logic [127:0] model_key = '0;
  logic         exp_kl    = 1'b0;
  int           exp_blk   = 0;

  // Stand-in cipher: real FIPS-197 vector for the known pair, a keyed mix otherwise.
  function automatic logic [127:0] cipher(input logic [127:0] key, input logic [127:0] pt);
    if (key == FIPS_KEY && pt == FIPS_PT) return FIPS_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  // Core model: BSY high for bsy_len cycles starting two cycles after a load pulse.
  int           bsy_len  = 0;
  int           bcnt     = 0;
  logic [127:0] core_key = '0;
  logic [127:0] core_res = '0;
  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) bcnt <= 0;
    else begin
      if (core_krdy) core_key <= core_kin;
      if (core_drdy) core_res <= cipher(core_key, core_din);
      if (core_krdy || core_drdy) bcnt <= bsy_len + 1;
      else if (bcnt != 0)         bcnt <= bcnt - 1;
    end
  end
  assign core_bsy  = (bcnt != 0) && (bcnt <= bsy_len);
  assign core_dout = core_res;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered/left at a negedge. Holds reset two cycles, then checks the first live cycle.
  task automatic do_reset(input string pfx);
    strm.s_valid = 1'b0;
    strm.m_ready = 1'b0;
    RSTn = 1'b0;
    #1;
    check({pfx, "_s_ready"},   strm.s_ready, 0);
    check({pfx, "_m_valid"},   strm.m_valid, 0);
    check({pfx, "_m_data"},    strm.m_data,  0);
    check({pfx, "_m_last"},    strm.m_last,  0);
    check({pfx, "_krdy"},      core_krdy,    0);
    check({pfx, "_drdy"},      core_drdy,    0);
    check({pfx, "_en"},        core_en,      0);
    check({pfx, "_kin"},       core_kin,     0);
    check({pfx, "_din"},       core_din,     0);
    check({pfx, "_key_loaded"}, key_loaded,  0);
    check({pfx, "_blk_cnt"},   blk_cnt,      0);
    exp_kl  = 1'b0;
    exp_blk = 0;
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    check({pfx, "_s_ready_up"}, strm.s_ready, 1);
    check({pfx, "_en_up"},      core_en,      1);
  endtask

  // Sends a packet LSW first with random gaps; krest gives s_is_key for words 1..3.
  task automatic send_pkt(input logic [127:0] pkt, input logic k0, input logic [2:0] krest);
    for (int w = 0; w < 4; w++) begin
      int   g;
      logic took;
      g    = 0;
      took = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      strm.s_valid  = 1'b1;
      strm.s_data   = pkt[32*w +: 32];
      strm.s_is_key = (w == 0) ? k0 : krest[w-1];
      while (!took && g < 50) begin
        took = strm.s_ready;
        @(posedge CLK);
        @(negedge CLK);
        g++;
      end
      strm.s_valid = 1'b0;
      check("send_accept", took, 1);
    end
  endtask

  // Starts at the negedge of cycle t+1; ends at the negedge where s_ready (key) or m_valid (data) rises.
  task automatic observe(input logic is_key, input logic [127:0] pkt);
    int   exp_k, k, extra, early, mv;
    logic done;
    exp_k = bsy_len + 4;
    k = 1; extra = 0; early = 0; mv = 0; done = 1'b0;
    check("pulse_krdy", core_krdy, is_key);
    check("pulse_drdy", core_drdy, !is_key);
    check("core_kin",   core_kin,  pkt);
    check("core_din",   core_din,  pkt);
    while (!done && k <= 60) begin
      if (k > 1 && (core_krdy || core_drdy)) extra++;
      if (is_key && strm.m_valid) mv++;
      done = is_key ? strm.s_ready : strm.m_valid;
      if (!done) begin
        if (strm.s_ready) early++;
        strm.s_valid = (k < exp_k - 1);
        strm.s_data  = $urandom;
        @(negedge CLK);
        k++;
      end
    end
    strm.s_valid = 1'b0;
    check("latency",        k,     exp_k);
    check("extra_pulses",   extra, 0);
    check("busy_s_ready",   early, 0);
    if (is_key) begin
      model_key = pkt;
      exp_kl    = 1'b1;
      check("key_no_m_valid", mv, 0);
    end else begin
      exp_blk = (exp_blk + 1) % (1 << CNT_W);
      check("blk_cnt", blk_cnt, exp_blk);
    end
    check("key_loaded", key_loaded, exp_kl);
  endtask

  // mode 0: m_ready high, 1: toggling, 2: random. abort_at >= 0 stops with that word on the bus.
  task automatic receive(input logic [127:0] exp, input int mode, input int abort_at);
    int          w, g;
    logic        stall, hs;
    logic [31:0] held;
    w = 0; g = 0; stall = 1'b0; held = '0;
    while (w < 4 && g < 200) begin
      case (mode)
        0:       strm.m_ready = 1'b1;
        1:       strm.m_ready = (g % 2 == 0);
        default: strm.m_ready = 1'($urandom_range(0, 1));
      endcase
      check("m_valid",      strm.m_valid, 1);
      check("m_data",       strm.m_data,  exp[32*w +: 32]);
      check("m_last",       strm.m_last,  (w == 3));
      check("out_s_ready",  strm.s_ready, 0);
      if (stall) check("m_data_hold", strm.m_data, held);
      if (w == abort_at) break;
      hs    = strm.m_valid && strm.m_ready;
      stall = !strm.m_ready;
      held  = strm.m_data;
      @(posedge CLK);
      if (hs) w++;
      @(negedge CLK);
      g++;
    end
    strm.m_ready = 1'b0;
    if (abort_at < 0) begin
      check("rx_words",      w,            4);
      check("s_ready_after", strm.s_ready, 1);
      check("m_valid_after", strm.m_valid, 0);
    end
  endtask

  initial begin
    logic [127:0] pt;
    strm.s_valid  = 1'b0;
    strm.s_data   = '0;
    strm.s_is_key = 1'b0;
    strm.m_ready  = 1'b0;
    #2;
    do_reset("por");

    // Key load, then the FIPS-197 block with m_ready held high.
    bsy_len = 3;
    send_pkt(FIPS_KEY, 1'b1, 3'($urandom));
    observe(1'b1, FIPS_KEY);
    bsy_len = 2;
    send_pkt(FIPS_PT, 1'b0, 3'($urandom));
    observe(1'b0, FIPS_PT);
    receive(FIPS_CT, 0, -1);

    // Same block under toggling backpressure.
    send_pkt(FIPS_PT, 1'b0, 3'($urandom));
    observe(1'b0, FIPS_PT);
    receive(FIPS_CT, 1, -1);

    // Latency with a 10-cycle BSY: m_valid must rise at t+14.
    bsy_len = 10;
    pt = {$urandom, $urandom, $urandom, $urandom};
    send_pkt(pt, 1'b0, 3'($urandom));
    observe(1'b0, pt);
    receive(cipher(model_key, pt), 2, -1);

    // Reset while waiting on BSY.
    bsy_len = 8;
    pt = {$urandom, $urandom, $urandom, $urandom};
    send_pkt(pt, 1'b0, 3'($urandom));
    repeat (4) @(negedge CLK);
    do_reset("rst_wait");

    // Reset while word 2 of the output is on the bus.
    bsy_len = 1;
    send_pkt(FIPS_KEY, 1'b1, 3'($urandom));
    observe(1'b1, FIPS_KEY);
    pt = {$urandom, $urandom, $urandom, $urandom};
    send_pkt(pt, 1'b0, 3'($urandom));
    observe(1'b0, pt);
    receive(cipher(model_key, pt), 0, 2);
    do_reset("rst_out");

    // Fresh key + plaintext after reset.
    send_pkt(FIPS_KEY, 1'b1, 3'($urandom));
    observe(1'b1, FIPS_KEY);
    send_pkt(FIPS_PT, 1'b0, 3'($urandom));
    observe(1'b0, FIPS_PT);
    receive(FIPS_CT, 0, -1);

    // Counter wrap over five blocks with key_loaded clear; core keeps its old key.
    do_reset("rst_wrap");
    for (int i = 0; i < 5; i++) begin
      bsy_len = $urandom_range(0, 4);
      pt = {$urandom, $urandom, $urandom, $urandom};
      send_pkt(pt, 1'b0, 3'($urandom));
      observe(1'b0, pt);
      receive(cipher(model_key, pt), $urandom_range(0, 2), -1);
    end

    // s_is_key high on word 2 only: still a plaintext packet.
    bsy_len = 2;
    pt = {$urandom, $urandom, $urandom, $urandom};
    send_pkt(pt, 1'b0, 3'b010);
    observe(1'b0, pt);
    receive(cipher(model_key, pt), 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end
endmodule
